// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai31_bist_pkg.sv
// Shared types and helpers for the OAI31 cell-bank BIST sequencer.
package gf180mcu_fd_sc_mcu7t5v0__oai31_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_t;

    // Every input combination of A1/A2/A3/B is applied once per run.
    localparam int NUM_VEC = 16;
    localparam int PAT_W   = 4;

    // Golden OAI31 response: ZN = !((A1|A2|A3)&B)
    function automatic logic oai31_exp(input logic a1, input logic a2,
                                       input logic a3, input logic b);
        return ~((a1 | a2 | a3) & b);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl_if.sv
// Host/cell-bank bundle for the OAI31 BIST sequencer.
// slave  : sequencer side (drives stimulus and results)
// master : host/bank side (drives START/ABORT and the observed ZN nets)
interface gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl_if #(
    parameter int NUM_DUT = 4
);
    import gf180mcu_fd_sc_mcu7t5v0__oai31_bist_pkg::*;

    logic               start;
    logic               abort;
    logic [NUM_DUT-1:0] zn_in;
    logic               a1;
    logic               a2;
    logic               a3;
    logic               b;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_DUT-1:0] fail_mask;
    logic [PAT_W-1:0]   first_fail_vec;
    logic               first_fail_vld;

    modport slave (
        input  start, abort, zn_in,
        output a1, a2, a3, b, busy, done, pass,
               fail_mask, first_fail_vec, first_fail_vld
    );

    modport master (
        output start, abort, zn_in,
        input  a1, a2, a3, b, busy, done, pass,
               fail_mask, first_fail_vec, first_fail_vld
    );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai31_bist_vecgen.sv
// Vector index counter and index-to-pattern mapping for the OAI31 BIST.
// Build option: GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_GRAY_EN selects Gray
// ordering (one input toggles per step); otherwise patterns are binary.
// The index never wraps: it parks at the last vector until cleared.
module gf180mcu_fd_sc_mcu7t5v0__oai31_bist_vecgen
    import gf180mcu_fd_sc_mcu7t5v0__oai31_bist_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PAT_W-1:0] o_pat_first,
    output logic [PAT_W-1:0] o_pat_next,
    output logic             o_last
);

    logic [PAT_W-1:0] r_vec;
    logic [PAT_W-1:0] w_vec_nxt;

    function automatic logic [PAT_W-1:0] pat_map(input logic [PAT_W-1:0] v);
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    assign w_vec_nxt   = r_vec + 4'd1;
    assign o_last      = (r_vec == PAT_W'(NUM_VEC - 1));
    assign o_pat_first = pat_map('0);
    assign o_pat_next  = pat_map(w_vec_nxt);

    // Index: cleared at run start/abort, advanced after each sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vec <= '0;
        end else if (i_clr) begin
            r_vec <= '0;
        end else if (i_inc && !o_last) begin
            r_vec <= w_vec_nxt;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl.sv
// BIST sequencer for a bank of OAI31 cells: applies all 16 input
// combinations, waits SETTLE_CYC cycles per vector, compares each ZN
// with the golden response and accumulates a sticky fail mask.
// Build option: GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_GRAY_EN (Gray pattern
// order, handled inside the vecgen sub-module).
//
// state  | meaning
// IDLE   | waiting for START, stimulus 0, results cleared
// SETTLE | vector applied, counting down settle time
// SAMPLE | compare ZN against expected, step or finish
// DONE   | results held, DONE/PASS valid until START or ABORT
module gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl
    import gf180mcu_fd_sc_mcu7t5v0__oai31_bist_pkg::*;
#(
    parameter int NUM_DUT    = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl_if.slave   bus
);

    localparam logic [3:0] CNT_RLD = 4'(SETTLE_CYC - 1);

    bist_state_t        r_state;
    bist_state_t        w_state_nxt;
    logic [3:0]         r_cnt;
    logic [PAT_W-1:0]   r_stim;
    logic [NUM_DUT-1:0] r_fail_mask;
    logic [PAT_W-1:0]   r_ffv;
    logic               r_ffv_vld;

    logic               w_run_start;
    logic               w_step;
    logic               w_finish;
    logic               w_abort;
    logic               w_cnt_dec;
    logic               w_exp;
    logic [NUM_DUT-1:0] w_mism;
    logic [PAT_W-1:0]   w_pat_first;
    logic [PAT_W-1:0]   w_pat_next;
    logic               w_last;

    gf180mcu_fd_sc_mcu7t5v0__oai31_bist_vecgen u_vecgen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_run_start | w_abort),
        .i_inc       (w_step),
        .o_pat_first (w_pat_first),
        .o_pat_next  (w_pat_next),
        .o_last      (w_last)
    );

    // Golden value derived from the pattern currently on the nets.
    assign w_exp  = oai31_exp(r_stim[3], r_stim[2], r_stim[1], r_stim[0]);
    assign w_mism = bus.zn_in ^ {NUM_DUT{w_exp}};

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; ABORT overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_run_start = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        w_cnt_dec   = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_abort     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_SETTLE;
                        w_run_start = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                        w_finish    = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_step      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Registered stimulus; forced to 0 whenever the run is not active.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stim <= '0;
        end else if (w_abort || w_finish) begin
            r_stim <= '0;
        end else if (w_run_start) begin
            r_stim <= w_pat_first;
        end else if (w_step) begin
            r_stim <= w_pat_next;
        end
    end

    // Settle down-counter, reloaded whenever a new vector is applied.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_abort) begin
            r_cnt <= '0;
        end else if (w_run_start || w_step) begin
            r_cnt <= CNT_RLD;
        end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Sticky fail mask and first-failing pattern capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fail_mask <= '0;
            r_ffv       <= '0;
            r_ffv_vld   <= 1'b0;
        end else if (w_abort || w_run_start) begin
            r_fail_mask <= '0;
            r_ffv       <= '0;
            r_ffv_vld   <= 1'b0;
        end else if (r_state == ST_SAMPLE) begin
            r_fail_mask <= r_fail_mask | w_mism;
            if ((|w_mism) && !r_ffv_vld) begin
                r_ffv     <= r_stim;
                r_ffv_vld <= 1'b1;
            end
        end
    end

    assign bus.a1             = r_stim[3];
    assign bus.a2             = r_stim[2];
    assign bus.a3             = r_stim[1];
    assign bus.b              = r_stim[0];
    assign bus.busy           = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign bus.done           = (r_state == ST_DONE);
    assign bus.pass           = (r_state == ST_DONE) && (r_fail_mask == '0);
    assign bus.fail_mask      = r_fail_mask;
    assign bus.first_fail_vec = r_ffv;
    assign bus.first_fail_vld = r_ffv_vld;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl.sv
// Self-checking bench for the OAI31 BIST sequencer: behavioural cell
// models with injectable faults, a table of directed runs, randomized
// fault runs against a reference model, and multi-cycle corner cases.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl_if #(.NUM_DUT(4)) if0 ();
    gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl_if #(.NUM_DUT(4)) if1 ();

    gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl #(.NUM_DUT(4), .SETTLE_CYC(2)) u_dut0 (
        .i_clk (clk), .i_rst (rst), .bus (if0)
    );
    gf180mcu_fd_sc_mcu7t5v0__oai31_bist_ctrl #(.NUM_DUT(4), .SETTLE_CYC(1)) u_dut1 (
        .i_clk (clk), .i_rst (rst), .bus (if1)
    );

    int n_err = 0;
    int n_chk = 0;

    // fault mode per cell: 0 good, 1 ZN stuck-at-1, 2 stuck-at-0, 3 inverted on pattern fpat
    int fmode [4];
    int fpat  [4];

    function automatic logic gold(input logic [3:0] p);
        return !((p[3] | p[2] | p[1]) & p[0]);
    endfunction

    function automatic logic zn_model(input logic [3:0] p, input int mode, input int fp);
        case (mode)
            1: return 1'b1;
            2: return 1'b0;
            3: return (p == 4'(fp)) ? !gold(p) : gold(p);
            default: return gold(p);
        endcase
    endfunction

    function automatic logic [3:0] pat_of(input int k);
        logic [3:0] v;
        v = 4'(k);
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    wire [3:0]  pat0  = {if0.a1, if0.a2, if0.a3, if0.b};
    wire [3:0]  pat1  = {if1.a1, if1.a2, if1.a3, if1.b};
    wire [15:0] outs0 = {pat0, if0.busy, if0.done, if0.pass, if0.fail_mask,
                         if0.first_fail_vec, if0.first_fail_vld};
    wire [15:0] outs1 = {pat1, if1.busy, if1.done, if1.pass, if1.fail_mask,
                         if1.first_fail_vec, if1.first_fail_vld};

    always_comb begin
        if0.zn_in = '0;
        for (int i = 0; i < 4; i++) if0.zn_in[i] = zn_model(pat0, fmode[i], fpat[i]);
    end

    always_comb begin
        if1.zn_in = {4{gold(pat1)}};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: walk the 16 patterns, compare each faulty cell with the golden response.
    task automatic model_run(output logic [3:0] m, output logic [3:0] f, output logic v);
        logic [3:0] p;
        m = '0; f = '0; v = 1'b0;
        for (int k = 0; k < 16; k++) begin
            p = pat_of(k);
            for (int i = 0; i < 4; i++) begin
                if (zn_model(p, fmode[i], fpat[i]) != gold(p)) begin
                    m[i] = 1'b1;
                    if (!v) begin
                        v = 1'b1;
                        f = p;
                    end
                end
            end
        end
    endtask

    // Full run on instance 0 (SETTLE_CYC=2); optional START re-pulse at edge 'repulse'.
    task automatic run0(input string tag, input int repulse, input logic [3:0] emask,
                        input logic [3:0] effv, input logic evld);
        int done_edge, k, seq_bad, idle_bad;
        logic [3:0] last;
        done_edge = -1; k = 0; seq_bad = 0; idle_bad = 0; last = '0;
        @(negedge clk);
        if0.start = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            @(negedge clk);
            if0.start = (e == repulse);
            if (e == 1) chk({tag, "/busy_rise"}, 32'(if0.busy), 32'd1);
            if (if0.busy) begin
                if (k == 0 || pat0 != last) begin
                    if (k >= 16 || pat0 != pat_of(k)) seq_bad++;
                    last = pat0;
                    k++;
                end
            end else if (pat0 != 4'd0) begin
                idle_bad++;
            end
            if (if0.done) begin
                done_edge = e;
                break;
            end
        end
        if0.start = 1'b0;
        chk({tag, "/done_edge"}, 32'(done_edge), 32'd49);
        chk({tag, "/vec_count"}, 32'(k), 32'd16);
        chk({tag, "/stim_order"}, 32'(seq_bad), 32'd0);
        chk({tag, "/stim_zero_idle"}, 32'(idle_bad), 32'd0);
        chk({tag, "/busy_fall"}, 32'(if0.busy), 32'd0);
        chk({tag, "/fail_mask"}, 32'(if0.fail_mask), 32'(emask));
        chk({tag, "/pass"}, 32'(if0.pass), 32'(emask == 4'd0));
        chk({tag, "/ffv_vld"}, 32'(if0.first_fail_vld), 32'(evld));
        chk({tag, "/ffv"}, 32'(if0.first_fail_vec), 32'(effv));
        repeat (3) @(negedge clk);
        chk({tag, "/done_hold"}, 32'({if0.done, if0.fail_mask, pat0}), 32'({1'b1, emask, 4'd0}));
    endtask

    typedef struct packed {
        logic [7:0] md;
        logic [3:0] mask;
        logic [3:0] ffv;
        logic       vld;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [3:0] em, ef;
        logic       ev;
        int done_edge, k, seq_bad, tog_bad;
        logic [3:0] last;

        tbl[0] = '{md: 8'b00_00_00_00, mask: 4'b0000, ffv: 4'b0000, vld: 1'b0};
        tbl[1] = '{md: 8'b00_00_01_00, mask: 4'b0010, ffv: 4'b0011, vld: 1'b1};
        tbl[2] = '{md: 8'b00_00_00_00, mask: 4'b0000, ffv: 4'b0000, vld: 1'b0};
        tbl[3] = '{md: 8'b10_00_00_00, mask: 4'b1000, ffv: 4'b0000, vld: 1'b1};
        tbl[4] = '{md: 8'b00_10_00_01, mask: 4'b0101, ffv: 4'b0000, vld: 1'b1};

        for (int i = 0; i < 4; i++) begin fmode[i] = 0; fpat[i] = 0; end
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outs0", 32'(outs0), 32'd0);
        chk("reset_outs1", 32'(outs1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(outs0), 32'd0);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 4; i++) fmode[i] = int'(tbl[t].md[2*i +: 2]);
            run0($sformatf("tbl%0d", t), 0, tbl[t].mask, tbl[t].ffv, tbl[t].vld);
        end

        for (int i = 0; i < 4; i++) fmode[i] = 0;
        run0("repulse", 10, 4'b0000, 4'b0000, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                fmode[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                fpat[i]  = int'($urandom_range(0, 15));
            end
            model_run(em, ef, ev);
            run0($sformatf("rand%0d", r), 0, em, ef, ev);
        end

        // ABORT sampled at edge 20 with cell 0 faulty.
        for (int i = 0; i < 4; i++) begin fmode[i] = 0; fpat[i] = 0; end
        fmode[0] = 2;
        @(negedge clk);
        if0.start = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            @(negedge clk);
            if0.start = 1'b0;
        end
        chk("abort/pre_mask", 32'(if0.fail_mask), 32'd1);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        chk("abort/idle_outs", 32'(outs0), 32'd0);
        @(negedge clk);
        chk("abort/stays_idle", 32'(if0.busy), 32'd0);

        // START and ABORT together in IDLE.
        if0.start = 1'b1; if0.abort = 1'b1;
        @(negedge clk);
        if0.start = 1'b0; if0.abort = 1'b0;
        chk("start_abort/idle", 32'(outs0), 32'd0);
        @(negedge clk);
        chk("start_abort/stays", 32'(if0.busy), 32'd0);

        // Async reset in the middle of SETTLE.
        fmode[0] = 0;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst/busy_before", 32'(if0.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst/outs_immediate", 32'(outs0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst/idle_after", 32'(outs0), 32'd0);

        // Instance 1, SETTLE_CYC=1: timing, order and single-toggle property.
        done_edge = -1; k = 0; seq_bad = 0; tog_bad = 0; last = '0;
        @(negedge clk);
        if1.start = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            @(negedge clk);
            if1.start = 1'b0;
            if (if1.busy && (k == 0 || pat1 != last)) begin
                if (k > 0 && $countones(pat1 ^ last) != 1) tog_bad++;
                if (k >= 16 || pat1 != pat_of(k)) seq_bad++;
                last = pat1;
                k++;
            end
            if (if1.done) begin
                done_edge = e;
                break;
            end
        end
        chk("s1/done_edge", 32'(done_edge), 32'd33);
        chk("s1/vec_count", 32'(k), 32'd16);
        chk("s1/stim_order", 32'(seq_bad), 32'd0);
        chk("s1/pass", 32'({if1.pass, if1.fail_mask}), 32'({1'b1, 4'd0}));
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_GRAY_EN
        chk("s1/gray_one_toggle", 32'(tog_bad), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
